// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT buffer between the UART receiver and a slow consumer.
// Define UART_RX_FIFO_PERR_TAG_EN to store the parity-error tag with each byte.
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_flag,
    input  logic              parity_error,
    output logic              rx_flag_clr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_perr,
    output logic              rd_valid,
    input  logic              pop,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic              ovf,
    input  logic              ovf_clr
);

    localparam int PTR_W = $clog2(DEPTH);
`ifdef UART_RX_FIFO_PERR_TAG_EN
    localparam int ENTRY_W = DATA_W + 1;
`else
    localparam int ENTRY_W = DATA_W;
`endif
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        WAIT_LOW
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_nxt;
    logic               take;
    logic               wr_en;
    logic               rd_en;
    logic               ovf_set;

    function automatic logic [CNT_W-1:0] cnt_update(
        input logic [CNT_W-1:0] cnt,
        input logic             inc,
        input logic             dec
    );
        logic [CNT_W-1:0] res;
        res = cnt;
        if (inc && !dec) begin
            res = cnt + CNT_W'(1);
        end else if (dec && !inc) begin
            res = cnt - CNT_W'(1);
        end
        return res;
    endfunction

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        wr_en     = 1'b0;
        ovf_set   = 1'b0;
        unique case (state)
            IDLE: begin
                ovf_set = rx_flag && full;
`ifdef UART_RX_FIFO_PERR_TAG_EN
                take  = rx_flag && !full;
                wr_en = take;
`else
                // Corrupted bytes are acknowledged and discarded, so they never need room.
                take  = rx_flag && (parity_error || !full);
                wr_en = take && !parity_error;
`endif
                if (take) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                state_nxt = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!rx_flag) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef UART_RX_FIFO_PERR_TAG_EN
    assign wr_entry = {parity_error, rx_data};
    assign rd_perr  = head[DATA_W];
`else
    assign wr_entry = rx_data;
    assign rd_perr  = 1'b0;
`endif

    assign head      = mem[rd_ptr];
    assign rd_data   = head[DATA_W-1:0];
    assign rd_en     = pop && rd_valid;
    assign count_nxt = cnt_update(count, wr_en, rd_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            full        <= 1'b0;
            rd_valid    <= 1'b0;
            rx_flag_clr <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            state <= state_nxt;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count       <= count_nxt;
            full        <= (count_nxt == CNT_FULL);
            rd_valid    <= (count_nxt != '0);
            rx_flag_clr <= (state_nxt == ACK);
            ovf         <= ovf_set || (ovf && !ovf_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer that sits directly downstream of the UART receiver.
- Consumes the UART's single-byte `rx_data`/`rx_flag`/`parity_error` outputs and generates the `rx_flag_clr` acknowledge back to the UART.
- Stores received bytes in a first-word-fall-through FIFO, so a slow consumer (CPU, display shifter, command parser) no longer has to service every byte immediately.
- While the FIFO is full, the pending byte is held inside the UART instead of being overwritten.

Parameters:
- DATA_W, 8: width of one UART character; matches `uart_data_t`.
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH+1): width of the `count` output; derived, not overridden.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- rx_data  in  DATA_W  received character from the UART; valid while `rx_flag`=1.
- rx_flag  in  1  UART byte-pending flag; level, held until cleared.
- parity_error  in  1  parity status of the current `rx_data`; valid while `rx_flag`=1.
- rx_flag_clr  out  1  one-cycle registered pulse that clears the UART flag.
- rd_data  out  DATA_W  head-of-FIFO character (first-word fall-through).
- rd_perr  out  1  parity tag of the head entry (see Optional Feature).
- rd_valid  out  1  FIFO not empty; `rd_data` and `rd_perr` are valid.
- pop  in  1  consume the head entry; ignored when `rd_valid`=0.
- full  out  1  count == DEPTH.
- count  out  CNT_W  number of stored entries, 0..DEPTH.
- ovf  out  1  sticky: a byte arrived while the FIFO was full.
- ovf_clr  in  1  clears `ovf`.

Behaviour:
- Reset (`rst`=1 at a clock edge):
  - Pointers and `count` go to 0; FSM goes to IDLE.
  - `rx_flag_clr`=0, `ovf`=0, `rd_valid`=0, `full`=0.
  - Storage array is not reset; `rd_data`/`rd_perr` are don't-care while `rd_valid`=0.
- Capture FSM, states IDLE, ACK, WAIT_LOW:
  - IDLE, `rx_flag`=1 and `full`=0: write {`parity_error`, `rx_data`} at `wr_ptr` on this edge; go to ACK.
  - IDLE, `rx_flag`=1 and `full`=1: no write, no clear. Stay in IDLE; the byte waits inside the UART.
  - ACK: `rx_flag_clr`=1 for exactly this one cycle (registered output); go to WAIT_LOW unconditionally.
  - WAIT_LOW: `rx_flag_clr`=0; return to IDLE on the first cycle with `rx_flag`=0. This prevents double-capturing a flag whose clear has not yet propagated.
- Capture latency: `rx_flag` first seen high in IDLE at edge N → entry written at N, `rx_flag_clr` high during cycle N+1, `rd_valid` high from N+1 if the FIFO was empty.
- Read side:
  - `rd_data`/`rd_perr` always present `mem[rd_ptr]`.
  - `pop`=1 with `rd_valid`=1 advances `rd_ptr` at the edge.
- Pointers: log2(DEPTH) bits each, natural wrap from DEPTH-1 to 0.
- `count` update per edge:
  - +1 on write only; -1 on accepted pop only.
  - Unchanged on a simultaneous write and pop.
  - Write eligibility uses registered `full`, so a pop does not make room for a write in the same cycle.
- `pop` while empty: no pointer or count change, no error flag.
- `ovf`:
  - Set on any cycle with FSM=IDLE, `rx_flag`=1, `full`=1.
  - Cleared by `ovf_clr`; set wins if both occur in the same cycle.
- Reset mid-operation: an ACK pulse in flight is cancelled. If `rx_flag` is still high after reset, that byte is captured again normally.

Optional Feature:
- Macro: UART_RX_FIFO_PERR_TAG_EN.
- Defined:
  - Each entry is DATA_W+1 bits wide.
  - Bytes with `parity_error`=1 are stored; `rd_perr` reports the tag for the head entry.
- Undefined:
  - Entries are DATA_W bits; `rd_perr` is tied 0.
  - A byte with `parity_error`=1 is acknowledged through the normal IDLE→ACK→WAIT_LOW sequence but not written; `count` is unchanged.
  - Such a byte is acknowledged even when `full`=1.

Test Plan:
- Reset, then `rx_flag`=1 with `rx_data`=8'h41 until `rx_flag_clr`, dropping `rx_flag` the cycle after → one `rx_flag_clr` pulse; `count`=1, `rd_valid`=1, `rd_data`=8'h41.
- Write 8'h30..8'h3F (16 bytes, DEPTH=16), then a 17th byte 8'h55 → `full`=1, `ovf`=1, no `rx_flag_clr` for 8'h55. One `pop` → `rd_data` was 8'h30; 8'h55 is captured and acknowledged and `count` returns to 16.
- Steady state with `count`=5: assert `pop` in the same cycle as a capture → `count` stays 5 and FIFO order is preserved.
- Hold `rx_flag`=1 for 4 cycles after the `rx_flag_clr` pulse → exactly one entry written; FSM stays in WAIT_LOW until the flag drops.
- Byte 8'h7A with `parity_error`=1:
  - With UART_RX_FIFO_PERR_TAG_EN: stored, and `rd_perr`=1 at the head.
  - Without: `rx_flag_clr` pulses and `count` is unchanged.
- Assert `rst` in the ACK cycle with `count`=3 → next cycle `rx_flag_clr`=0, `count`=0, `rd_valid`=0; a still-high `rx_flag` is recaptured afterwards.
